// File: rtl/ref_mem_ctrl.sv
// ref_mem_ctrl: sequencer for the ME reference-window memory.
// Loads one window of NUM_ROWS rows, then runs one 8-row read sweep and
// four single-row sweeps (one per lane group). Issue is throttled by the PE
// array's ready and by a credit counter of reads still in flight.
// Optional build macro REF_MEM_CTRL_PERF_EN adds the stall_cnt output.
module ref_mem_ctrl #(
   parameter int NUM_ROWS = 64,
   parameter int MAX_OUT  = 4,
   parameter int ADDR_W   = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              ref_in_vld,
   input  logic              pe_ready,
   input  logic              Oda8R_va,
   input  logic              da1R_va,
   output logic              beg_en,
   output logic [ADDR_W-1:0] rd_address,
   output logic              rd8R_en,
   output logic [3:0]        rdR_sel,
   output logic              rd_issue,
   output logic              busy,
   output logic              done
`ifdef REF_MEM_CTRL_PERF_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StScan8 = 3'd2;
   localparam logic [2:0] StScan1 = 3'd3;
   localparam logic [2:0] StDrain = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   localparam logic [7:0]        LastRow   = 8'(NUM_ROWS - 1);
   localparam logic [ADDR_W-1:0] LastAddr8 = ADDR_W'(NUM_ROWS - 8);
   localparam logic [ADDR_W-1:0] LastAddr1 = ADDR_W'(NUM_ROWS - 1);
   localparam logic [ADDR_W-1:0] Step8     = ADDR_W'(8);
   localparam logic [ADDR_W-1:0] Step1     = ADDR_W'(1);
   localparam logic [3:0]        OutMax    = 4'(MAX_OUT);

   logic [2:0]        state_q, state_d;
   logic [7:0]        wcnt_q, wcnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        pass_q, pass_d;
   logic [3:0]        out_q, out_d;

   logic              beg_en_q;
   logic [ADDR_W-1:0] rd_address_q;
   logic              rd8R_en_q;
   logic [3:0]        rdR_sel_q;
   logic              rd_issue_q;
   logic              busy_q;
   logic              done_q;

   logic              scan;
   logic              can_issue;
   logic              issue;
   logic              any_va;
   logic              drain_empty;

   assign scan      = (state_q == StScan8) || (state_q == StScan1);
   assign can_issue = pe_ready && (out_q < OutMax);
   assign any_va    = Oda8R_va || da1R_va;
   // The returning strobe this cycle may empty the counter, so DRAIN can
   // exit without waiting an extra cycle for out_q to reach zero.
   assign drain_empty = (out_q == 4'd0) || ((out_q == 4'd1) && any_va);

   // Next-state for the sequencer: state, write count, read address, pass.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      pass_d  = pass_q;
      issue   = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               wcnt_d  = 8'd0;
               addr_d  = '0;
               pass_d  = 2'd0;
            end
         end
         StLoad: begin
            if (ref_in_vld) begin
               wcnt_d = wcnt_q + 8'd1;
               if (wcnt_q == LastRow) begin
                  state_d = StScan8;
                  addr_d  = '0;
               end
            end
         end
         StScan8: begin
            if (can_issue) begin
               issue = 1'b1;
               if (addr_q == LastAddr8) begin
                  state_d = StScan1;
                  addr_d  = '0;
                  pass_d  = 2'd0;
               end else begin
                  addr_d = addr_q + Step8;
               end
            end
         end
         StScan1: begin
            if (can_issue) begin
               issue = 1'b1;
               if (addr_q == LastAddr1) begin
                  addr_d = '0;
                  if (pass_q == 2'd3) begin
                     state_d = StDrain;
                  end else begin
                     pass_d = pass_q + 2'd1;
                  end
               end else begin
                  addr_d = addr_q + Step1;
               end
            end
         end
         StDrain: begin
            if (drain_empty) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Abort overrides everything, including a start in the same cycle.
      if (abort) begin
         state_d = StIdle;
         wcnt_d  = 8'd0;
         addr_d  = '0;
         pass_d  = 2'd0;
         issue   = 1'b0;
      end
   end

   // Credit counter: +1 per issue, -1 per valid strobe, saturating at zero.
   always_comb begin
      out_d = out_q;
      if (issue && !any_va) begin
         out_d = out_q + 4'd1;
      end else if (!issue && any_va && (out_q != 4'd0)) begin
         out_d = out_q - 4'd1;
      end
      if (abort) begin
         out_d = 4'd0;
      end
   end

   // Sequencer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         wcnt_q  <= 8'd0;
         addr_q  <= '0;
         pass_q  <= 2'd0;
         out_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         pass_q  <= pass_d;
         out_q   <= out_d;
      end
   end

   // Registered outputs, decided from the current state and inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beg_en_q     <= 1'b0;
         rd_address_q <= '0;
         rd8R_en_q    <= 1'b0;
         rdR_sel_q    <= 4'd0;
         rd_issue_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else if (abort) begin
         beg_en_q     <= 1'b0;
         rd_address_q <= '0;
         rd8R_en_q    <= 1'b0;
         rdR_sel_q    <= 4'd0;
         rd_issue_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         beg_en_q   <= (state_q == StLoad) && ref_in_vld;
         rd_issue_q <= issue;
         if (issue) begin
            rd_address_q <= addr_q;
         end else if ((state_q == StIdle) && start) begin
            rd_address_q <= '0;
         end
         rd8R_en_q <= (state_q == StScan8);
         rdR_sel_q <= (state_q == StScan1) ? (4'b0001 << pass_q) : 4'd0;
         busy_q    <= (state_d != StIdle);
         done_q    <= (state_d == StDone);
      end
   end

   assign beg_en     = beg_en_q;
   assign rd_address = rd_address_q;
   assign rd8R_en    = rd8R_en_q;
   assign rdR_sel    = rdR_sel_q;
   assign rd_issue   = rd_issue_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef REF_MEM_CTRL_PERF_EN
   logic [15:0] stall_q;

   // Count scan cycles where no read could issue; held in IDLE for readout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 16'd0;
      end else if ((state_q == StIdle) && start && !abort) begin
         stall_q <= 16'd0;
      end else if (scan && !can_issue && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Self-checking bench for ref_mem_ctrl: a memory model answers each read
// with a valid strobe after a chosen latency, and every observed issue is
// compared against the window's expected address/mode/lane sequence.
module tb_ref_mem_ctrl;

   localparam int NumRows = 64;
   localparam int MaxOut  = 4;
   localparam int AddrW   = 7;
   localparam int NumIss8 = NumRows / 8;
   localparam int NumIss  = NumIss8 + 4 * NumRows;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic             ref_in_vld;
   logic             pe_ready;
   logic             Oda8R_va = 1'b0;
   logic             da1R_va = 1'b0;
   logic             beg_en;
   logic [AddrW-1:0] rd_address;
   logic             rd8R_en;
   logic [3:0]       rdR_sel;
   logic             rd_issue;
   logic             busy;
   logic             done;
`ifdef REF_MEM_CTRL_PERF_EN
   logic [15:0]      stall_cnt;
`endif

   ref_mem_ctrl #(
      .NUM_ROWS (NumRows),
      .MAX_OUT  (MaxOut),
      .ADDR_W   (AddrW)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .ref_in_vld (ref_in_vld),
      .pe_ready   (pe_ready),
      .Oda8R_va   (Oda8R_va),
      .da1R_va    (da1R_va),
      .beg_en     (beg_en),
      .rd_address (rd_address),
      .rd8R_en    (rd8R_en),
      .rdR_sel    (rdR_sel),
      .rd_issue   (rd_issue),
      .busy       (busy),
      .done       (done)
`ifdef REF_MEM_CTRL_PERF_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Memory model and monitor state.
   int   cyc = 0;
   int   lat = 2;
   bit   rand_lat = 1'b0;
   bit   mem_hold = 1'b0;
   int   pend_due[$];
   bit   pend_8[$];
   int   n_issue = 0;
   int   n_beg = 0;
   int   n_done = 0;
   int   first_iss = -1;
   int   last_iss = -1;
   int   last_beg = -1;
   int   done_cyc = -1;
   logic [AddrW-1:0] iss_addr[$];
   bit               iss_8[$];
   logic [3:0]       iss_sel[$];

   // Sample outputs on the falling edge; answer reads in issue order.
   always @(negedge clk) begin
      cyc++;
      Oda8R_va = 1'b0;
      da1R_va  = 1'b0;
      if (!rst) begin
         if (rd_issue) begin
            n_issue++;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
            iss_addr.push_back(rd_address);
            iss_8.push_back(rd8R_en);
            iss_sel.push_back(rdR_sel);
            pend_due.push_back(cyc + (rand_lat ? int'($urandom_range(0, 4)) : lat));
            pend_8.push_back(rd8R_en);
         end
         if (beg_en) begin
            n_beg++;
            last_beg = cyc;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (!mem_hold && (pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
            void'(pend_due.pop_front());
            if (pend_8.pop_front()) Oda8R_va = 1'b1;
            else                    da1R_va  = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_window();
      n_issue   = 0;
      n_beg     = 0;
      n_done    = 0;
      first_iss = -1;
      last_iss  = -1;
      last_beg  = -1;
      done_cyc  = -1;
      iss_addr.delete();
      iss_8.delete();
      iss_sel.delete();
   endtask

   task automatic load_rows(input bit gaps);
      int rows;
      rows  = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      while (rows < NumRows) begin
         ref_in_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         step();
         if (ref_in_vld) rows++;
      end
      ref_in_vld = 1'b0;
   endtask

   task automatic run_to_done(input int budget, input bit rand_pe, input string tag);
      int k;
      k = 0;
      while ((n_done == 0) && (k < budget)) begin
         if (rand_pe) pe_ready = ($urandom_range(0, 3) != 0);
         step();
         k++;
      end
      pe_ready = 1'b1;
      check_val({tag, "_reached_done"}, (n_done != 0), 1);
      repeat (3) step();
      check_val({tag, "_done_pulses"}, n_done, 1);
      check_val({tag, "_busy_after"}, busy, 0);
   endtask

   // Expected issue k: NumRows/8 eight-row reads, then four full single-row sweeps.
   task automatic check_seq(input string tag);
      int bad;
      int j;
      int ea;
      bit e8;
      int es;
      bad = 0;
      for (int k = 0; k < iss_addr.size(); k++) begin
         if (k < NumIss8) begin
            ea = 8 * k;
            e8 = 1'b1;
            es = 0;
         end else begin
            j  = k - NumIss8;
            ea = j % NumRows;
            e8 = 1'b0;
            es = 1 << (j / NumRows);
         end
         if ((int'(iss_addr[k]) != ea) || (iss_8[k] != e8) || (int'(iss_sel[k]) != es)) bad++;
      end
      check_val({tag, "_issues"}, n_issue, NumIss);
      check_val({tag, "_seq_errs"}, bad, 0);
      check_val({tag, "_beg_rows"}, n_beg, NumRows);
      check_val({tag, "_read_after_load"}, (first_iss > last_beg), 1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_done"}, done, 0);
      check_val({tag, "_beg_en"}, beg_en, 0);
      check_val({tag, "_rd_issue"}, rd_issue, 0);
      check_val({tag, "_rd_address"}, rd_address, 0);
      check_val({tag, "_rd8R_en"}, rd8R_en, 0);
      check_val({tag, "_rdR_sel"}, rdR_sel, 0);
   endtask

   initial begin
      int a;
      int b;
      int k;
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      ref_in_vld = 1'b0;
      pe_ready   = 1'b1;
      repeat (3) step();
      check_outputs_zero("reset");
`ifdef REF_MEM_CTRL_PERF_EN
      check_val("reset_stall_cnt", stall_cnt, 0);
`endif
      rst = 1'b0;
      step();

      // Window A: steady load, latency 2, PE always ready.
      clear_window();
      lat = 2;
      load_rows(1'b0);
      run_to_done(3000, 1'b0, "win_a");
      check_seq("win_a");

      // Window B: credit limit with valids withheld, then random traffic.
      clear_window();
      lat      = 0;
      mem_hold = 1'b1;
      load_rows(1'b1);
      repeat (20) step();
      check_val("credit_stall", n_issue, MaxOut);
      @(posedge clk);
      mem_hold = 1'b0;
      @(posedge clk);
      mem_hold = 1'b1;
      #1;
      repeat (20) step();
      check_val("credit_release", n_issue, MaxOut + 1);
      mem_hold = 1'b0;
      rand_lat = 1'b1;
      run_to_done(6000, 1'b1, "win_b");
      rand_lat = 1'b0;
      check_seq("win_b");

      // Window C: PE not ready for 10 cycles in the middle of lane pass 1.
      clear_window();
      lat = 1;
      load_rows(1'b1);
      k = 0;
      while ((n_issue < NumIss8 + NumRows + 10) && (k < 2000)) begin
         step();
         k++;
      end
      check_val("pass1_reached", (k < 2000), 1);
      pe_ready = 1'b0;
      step();
      a = n_issue;
      repeat (9) step();
      b = n_issue;
      check_val("pe_hold_no_issue", b, a);
      check_val("pe_hold_addr", rd_address, iss_addr[iss_addr.size() - 1]);
      pe_ready = 1'b1;
      run_to_done(3000, 1'b0, "win_c");
      check_seq("win_c");
`ifdef REF_MEM_CTRL_PERF_EN
      check_val("stall_cnt", stall_cnt, 10);
`endif

      // Window D: valid returns with every issue; no credit stalls expected.
      clear_window();
      lat = 0;
      load_rows(1'b0);
      run_to_done(3000, 1'b0, "win_d");
      check_seq("win_d");
      check_val("back_to_back", last_iss - first_iss + 1, NumIss);
      check_val("drain_len", ((done_cyc - last_iss) >= 1) && ((done_cyc - last_iss) <= 2), 1);

      // Window E: abort with start at the 5th single-row issue, then restart.
      clear_window();
      lat = 2;
      load_rows(1'b0);
      k = 0;
      while ((n_issue < NumIss8 + 5) && (k < 2000)) begin
         step();
         k++;
      end
      check_val("abort_point_reached", (k < 2000), 1);
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      check_outputs_zero("abort");
      a = n_issue;
      repeat (10) step();
      check_val("abort_idle_busy", busy, 0);
      check_val("abort_idle_issues", n_issue, a);
      clear_window();
      load_rows(1'b1);
      run_to_done(3000, 1'b0, "win_e");
      check_seq("win_e");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
